imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Accepts one instruction word per handshake and decodes its RV32I immediate format.
- Sign-extends the immediate to XLEN and presents it one cycle later, together with the instruction, PC, format code and an illegal-opcode flag.
- A 2-entry elastic (main + skid) buffer gives full throughput under downstream back-pressure, with no combinational ready path from output to input.

Parameters:
- XLEN, 32, datapath width of imm/pc; legal values 32 or 64; immediates sign-extended from instr[31] to XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; equals !skid_valid (registered).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction; passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction of the output entry.
- out_pc  out  XLEN  PC of the output entry.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- out_illegal  out  1  opcode not recognised, or instr[1:0] != 2'b11.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: out_valid=0, skid_valid=0, in_ready=1; out_instr, out_pc and out_imm =0; out_fmt=0; out_illegal=0. Reset mid-stall discards both entries.
- Decode (combinational on in_instr, registered on capture); opcode = instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011 -> I; imm = sext(instr[31:20]).
  - 0100011 -> S; imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 -> B; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 -> U; imm = sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 = instr[31].
  - 1101111 -> J; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0001111 (FENCE), 0110011 (OP) -> NONE; imm=0; legal.
  - Any other opcode, or instr[1:0] != 11 -> NONE; imm=0; illegal=1. The entry is still passed downstream; it is never dropped.
- Handshake:
  - accept = in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Per-cycle update:
  - If !out_valid | out_ready: main loads the skid entry if skid_valid (skid_valid<=0); else main loads the input if accept; else out_valid<=0.
  - Otherwise (stalled): if accept, the input is captured into skid (skid_valid<=1).
- Ordering is strictly FIFO.
- Latency: input-to-output is 1 cycle when the buffer is empty.
- Throughput: 1 per cycle while out_ready=1.
- Full: skid_valid=1 -> in_ready=0. in_ready returns to 1 the cycle after main drains and skid moves into main.
- Output stability: while out_valid & !out_ready, all out_* fields hold stable.
- Simultaneous output transfer and input accept with skid empty: main is replaced by the new input in the same cycle, with no bubble.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> fmt Z, imm = zero-extended instr[19:15].
- Undefined: these instructions decode as I-type like the rest of SYSTEM.

Test Plan:
- ADDI 0xFFF00093, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- SW 0xFE112E23 -> imm 0xFFFFFFFC, fmt 2. BEQ 0xFE000CE3 -> imm 0xFFFFFFF8, fmt 3. JAL 0x0000006F -> imm 0, fmt 5.
- LUI 0x123452B7 -> imm 0x12345000, fmt 4. With XLEN=64, LUI 0x800002B7 -> imm 0xFFFFFFFF80000000.
- Back-pressure: hold out_ready=0 and send 3 back-to-back instructions. Expect the first held in main, the second in skid, in_ready=0 on the third. Release out_ready -> outputs appear in order with no duplicates or losses; in_ready=1 one cycle after the first drain.
- 0x0000007F and 0x00000013 with bit0 cleared (0x00000012) -> both delivered with illegal=1, fmt 0, imm 0.
- CSRRWI 0x3002D073 -> macro defined: imm 5, fmt 6; macro undefined: imm 0x300, fmt 1. Assert rst while stalled with 2 entries -> next cycle out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Purpose : RV32I immediate generator for decode, registered behind a 2-entry main+skid elastic buffer.
// Latency : 1 cycle from input accept to out_valid when the buffer is empty; 1 instruction/cycle sustained.
// Backpr. : in_ready is !skid_valid (register-driven), so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        upstream handshake; in_instr (32b) and in_pc (XLEN) captured on accept
//   out_valid/out_ready      downstream handshake; out_* fields stay stable while stalled
//   out_instr, out_pc        instruction and PC of the output entry
//   out_imm                  decoded immediate, extended to XLEN
//   out_fmt                  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
//   out_illegal              unrecognised opcode or instr[1:0] != 2'b11
//
// Build option: define IMM_GEN_ZICSR_EN to decode CSRRWI/CSRRSI/CSRRCI as format Z
// (imm = zero-extended instr[19:15]); otherwise they decode as I-type like the rest of SYSTEM.
//
// Parameter XLEN: 32 or 64.

module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    // One buffered decode result.
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    logic   main_vld;
    logic   skid_vld;
    entry_t dec_dat;
    logic   accept;

    // ------------------------------------------------------------------
    // Decode. Every immediate is first formed as a 32-bit value whose
    // bit 31 is already the correct extension bit (instr[31] for the
    // signed formats, 0 for zimm/NONE), then replicated up to XLEN.
    // ------------------------------------------------------------------
    logic [31:0] imm32;
    logic [2:0]  fmt;
    logic        illegal;

    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        // All recognised opcodes end in 2'b11, so a bad instr[1:0]
        // always lands in the default branch.
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_SYS: begin
`ifdef IMM_GEN_ZICSR_EN
                if (in_instr[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, in_instr[19:15]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
`else
                fmt   = FMT_I;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BR: begin
                fmt   = FMT_B;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_FENCE, OP_OP: begin
                fmt   = FMT_NONE;
            end
            default: begin
                // Passed downstream flagged, never dropped.
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec_dat           = '0;
        dec_dat.instr     = in_instr;
        dec_dat.pc        = in_pc;
        dec_dat.imm       = {XLEN{imm32[31]}};
        dec_dat.imm[31:0] = imm32;
        dec_dat.fmt       = fmt;
        dec_dat.illegal   = illegal;
    end

    // ------------------------------------------------------------------
    // Elastic buffer. The skid entry only fills when main is stalled, and
    // is always drained into main before new input, keeping FIFO order.
    // ------------------------------------------------------------------
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_ready) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                // Covers the simultaneous drain+accept case with no bubble.
                main_q   <= dec_dat;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= dec_dat;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid   = main_vld;
    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose : scoreboard bench for imm_gen_pipe (XLEN=32 main instance, XLEN=64 side instance).
// Latency : expected entries queued on accept, popped by an independent output monitor.
// Backpr. : exercises stalls with out_ready=0, skid fill, drain ordering and reset mid-stall.

module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_instr(out_instr64), .out_pc(out_pc64),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic ill);
        exp_t e;
        e.instr  = ins;
        e.pc     = pc_ctr;
        e.imm    = imm;
        e.fmt    = fmt;
        e.ill    = ill;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_ctr;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                q.push_back(e);
                pc_ctr = pc_ctr + 32'd4;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: instr %h never accepted, in_ready got %b expected 1", ins, in_ready);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples between negedge and the next active edge.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got instr=%h expected no output", out_instr);
            end else begin
                mon_e = q.pop_front();
                if ({out_instr, out_pc, out_imm, out_fmt, out_illegal} !==
                    {mon_e.instr, mon_e.pc, mon_e.imm, mon_e.fmt, mon_e.ill}) begin
                    errors++;
                    $display("FAIL out_entry: got instr=%h pc=%h imm=%h fmt=%0d ill=%b expected instr=%h pc=%h imm=%h fmt=%0d ill=%b",
                             out_instr, out_pc, out_imm, out_fmt, out_illegal,
                             mon_e.instr, mon_e.pc, mon_e.imm, mon_e.fmt, mon_e.ill);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        out_ready   = 1'b1;
        in_valid64  = 1'b0;
        in_instr64  = '0;
        in_pc64     = '0;
        out_ready64 = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_in_ready",    64'(in_ready),    64'd1);
        chk("rst_out_instr",   64'(out_instr),   64'd0);
        chk("rst_out_pc",      64'(out_pc),      64'd0);
        chk("rst_out_imm",     64'(out_imm),     64'd0);
        chk("rst_out_fmt",     64'(out_fmt),     64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream with out_ready=1: drain and accept share cycles.
        send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);  // ADDI x1,x0,-1
        chk("latency_1cycle_valid", 64'(out_valid), 64'd1);
        send(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);  // SW
        send(32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0);  // BEQ -8
        send(32'h0000006F, 32'h00000000, 3'd5, 1'b0);  // JAL 0
        send(32'h123452B7, 32'h12345000, 3'd4, 1'b0);  // LUI
        send(32'h800002B7, 32'h80000000, 3'd4, 1'b0);  // LUI, top bit set
        send(32'hFFFFF117, 32'hFFFFF000, 3'd4, 1'b0);  // AUIPC
        send(32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0);  // JAL -4
        send(32'h00412083, 32'h00000004, 3'd1, 1'b0);  // LW
        send(32'h00000033, 32'h00000000, 3'd0, 1'b0);  // ADD
        send(32'h0000000F, 32'h00000000, 3'd0, 1'b0);  // FENCE
        send(32'h0000007F, 32'h00000000, 3'd0, 1'b1);  // unknown opcode
        send(32'h00000012, 32'h00000000, 3'd0, 1'b1);  // ADDI with bit0 cleared
`ifdef IMM_GEN_ZICSR_EN
        send(32'h3002D073, 32'h00000005, 3'd6, 1'b0);  // CSRRWI zimm
`else
        send(32'h3002D073, 32'h00000300, 3'd1, 1'b0);  // CSRRWI as I-type
`endif
        idle(4);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Back-pressure: A into main, B into skid, C blocked.
        out_ready = 1'b0;
        send(32'h00100093, 32'h00000001, 3'd1, 1'b0);  // A
        send(32'h00200113, 32'h00000002, 3'd1, 1'b0);  // B
        in_valid = 1'b1;
        in_instr = 32'h00300193;                        // C
        in_pc    = pc_ctr;
        chk("full_in_ready_low", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("stall_in_ready_low", 64'(in_ready),  64'd0);
        chk("stall_hold_instr",   64'(out_instr), 64'h00100093);
        chk("stall_hold_imm",     64'(out_imm),   64'h1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_drain", 64'(in_ready), 64'd1);
        send(32'h00300193, 32'h00000003, 3'd1, 1'b0);  // C
        idle(4);
        chk("backpressure_drained", 64'(q.size()), 64'd0);

        // Reset while stalled with both entries full.
        out_ready = 1'b0;
        send(32'h00400213, 32'h00000004, 3'd1, 1'b0);
        send(32'h00500293, 32'h00000005, 3'd1, 1'b0);
        in_valid = 1'b0;
        chk("pre_reset_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("midstall_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midstall_rst_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        idle(3);

        // XLEN=64: U-type upper word comes from instr[31].
        chk("x64_in_ready", 64'(in_ready64), 64'd1);
        in_valid64 = 1'b1;
        in_instr64 = 32'h800002B7;
        in_pc64    = 64'h8000_0000_0000_0010;
        @(negedge clk);
        in_valid64 = 1'b0;
        chk("x64_out_valid", 64'(out_valid64),   64'd1);
        chk("x64_lui_imm",   out_imm64,          64'hFFFFFFFF80000000);
        chk("x64_lui_fmt",   64'(out_fmt64),     64'd4);
        chk("x64_pc",        out_pc64,           64'h8000_0000_0000_0010);
        chk("x64_illegal",   64'(out_illegal64), 64'd0);
        chk("x64_instr",     64'(out_instr64),   64'h800002B7);
        @(negedge clk);
        chk("x64_drained", 64'(out_valid64), 64'd0);

        idle(2);
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
